// File: rtl/alu_exec_stage_if.sv
// alu_exec_stage_if: operation/result handshake bundle for the ALU execute stage
// Signals: in_valid/in_ready/gout/a/b (operation in), out_valid/out_ready/result/
// zero/overflow/branch_taken/illegal (queue head out), occupancy (queued entries).
// Modports: master = producer/consumer side, slave = execute stage.
interface alu_exec_stage_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
);
    logic                       in_valid;
    logic                       in_ready;
    logic [3:0]                 gout;
    logic [WIDTH-1:0]           a;
    logic [WIDTH-1:0]           b;
    logic                       out_valid;
    logic                       out_ready;
    logic [WIDTH-1:0]           result;
    logic                       zero;
    logic                       overflow;
    logic                       branch_taken;
    logic                       illegal;
    logic [$clog2(DEPTH+1)-1:0] occupancy;
    modport master (
        output in_valid, gout, a, b, out_ready,
        input  in_ready, out_valid, result, zero, overflow, branch_taken, illegal, occupancy
    );
    modport slave (
        input  in_valid, gout, a, b, out_ready,
        output in_ready, out_valid, result, zero, overflow, branch_taken, illegal, occupancy
    );
endinterface

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: ALU execute stage with combinational compute feeding a DEPTH-entry result queue
// Ports: clk (rising edge), reset (async, active-high), bus (alu_exec_stage_if.slave:
// operation handshake in, result/flag handshake out, occupancy).
module alu_exec_stage #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input logic            clk,
    input logic            reset,
    alu_exec_stage_if.slave bus
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             overflow;
        logic             taken;
        logic             illegal;
    } entry_t;
    entry_t           mem_q [DEPTH];
    entry_t           new_e;
    entry_t           head;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] sum, diff;
    logic             sa, sb, a_zero, push, pop, out_valid;
    assign sum    = bus.a + bus.b;
    assign diff   = bus.a - bus.b;
    assign sa     = bus.a[WIDTH-1];
    assign sb     = bus.b[WIDTH-1];
    assign a_zero = bus.a == '0;
    always_comb begin
        new_e = '0;
        case (bus.gout)
            4'b0000: begin
                new_e.result   = sum;
                new_e.overflow = (sa == sb) && (sum[WIDTH-1] != sa);
            end
            4'b0001: begin
                new_e.result   = diff;
                new_e.overflow = (sa != sb) && (diff[WIDTH-1] != sa);
            end
            4'b0010: new_e.result = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
            4'b0011: new_e.result = bus.a | bus.b;
            4'b0100: new_e.result = bus.a & bus.b;
            4'b0101: new_e.result = ~(bus.a | bus.b);
            4'b0110: begin
                new_e.result = diff;
                new_e.taken  = bus.a == bus.b;
            end
            4'b0111: begin
                new_e.result = diff;
                new_e.taken  = bus.a != bus.b;
            end
            4'b1000: begin
                new_e.result = bus.a;
                new_e.taken  = !sa;
            end
            4'b1001: begin
                new_e.result = bus.a;
                new_e.taken  = !sa && !a_zero;
            end
            4'b1010: begin
                new_e.result = bus.a;
                new_e.taken  = sa || a_zero;
            end
            4'b1011: begin
                new_e.result = bus.a;
                new_e.taken  = sa;
            end
            default: new_e.illegal = 1'b1;
        endcase
    end
    assign out_valid  = count_q != '0;
    // in_ready looks only at registered count: a full queue never passes through on a same-cycle pop
    assign bus.in_ready = count_q < CW'(DEPTH);
    assign push       = bus.in_valid && bus.in_ready;
    assign pop        = out_valid && bus.out_ready;
    assign head       = mem_q[rd_ptr_q];
    always_comb begin
        wr_ptr_d = push ? (wr_ptr_q == PW'(DEPTH - 1) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d = pop ? (rd_ptr_q == PW'(DEPTH - 1) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) mem_q[wr_ptr_q] <= new_e;
        end
    end
    assign bus.out_valid    = out_valid;
    assign bus.occupancy    = count_q;
    assign bus.result       = out_valid ? head.result : '0;
    assign bus.zero         = out_valid && head.result == '0;
    assign bus.overflow     = out_valid && head.overflow;
    assign bus.branch_taken = out_valid && head.taken;
    assign bus.illegal      = out_valid && head.illegal;
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: directed vector table plus backpressure, streaming and async-reset sequences
module tb_alu_exec_stage;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    alu_exec_stage_if #(.WIDTH(32), .DEPTH(2)) bus ();
    alu_exec_stage #(.WIDTH(32), .DEPTH(2)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    typedef struct {
        logic [3:0]  g;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        z;
        logic        o;
        logic        t;
        logic        il;
    } vec_t;
    vec_t vt [27];
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", n, act, exp);
        end
    endtask
    task automatic drive(input logic [3:0] g, input logic [31:0] a, input logic [31:0] b);
        bus.gout     = g;
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask
    initial begin
        vt[0]  = '{4'b0000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 1, 0, 0};
        vt[1]  = '{4'b0000, 32'h80000000, 32'h80000000, 32'h00000000, 1, 1, 0, 0};
        vt[2]  = '{4'b0000, 32'h00000003, 32'h00000004, 32'h00000007, 0, 0, 0, 0};
        vt[3]  = '{4'b0001, 32'h00000005, 32'h00000005, 32'h00000000, 1, 0, 0, 0};
        vt[4]  = '{4'b0001, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 0, 1, 0, 0};
        vt[5]  = '{4'b0001, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 0, 1, 0, 0};
        vt[6]  = '{4'b0010, 32'hFFFFFFFE, 32'h00000001, 32'h00000001, 0, 0, 0, 0};
        vt[7]  = '{4'b0010, 32'h00000001, 32'hFFFFFFFE, 32'h00000000, 1, 0, 0, 0};
        vt[8]  = '{4'b0011, 32'h000000F0, 32'h0000000F, 32'h000000FF, 0, 0, 0, 0};
        vt[9]  = '{4'b0100, 32'h000000F0, 32'h0000003C, 32'h00000030, 0, 0, 0, 0};
        vt[10] = '{4'b0101, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 0, 0, 0, 0};
        vt[11] = '{4'b0110, 32'h00000005, 32'h00000005, 32'h00000000, 1, 0, 1, 0};
        vt[12] = '{4'b0111, 32'h00000005, 32'h00000005, 32'h00000000, 1, 0, 0, 0};
        vt[13] = '{4'b0110, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 0, 0, 0, 0};
        vt[14] = '{4'b0111, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 0, 0, 1, 0};
        vt[15] = '{4'b1011, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 0, 0, 1, 0};
        vt[16] = '{4'b1000, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 0, 0, 0, 0};
        vt[17] = '{4'b1010, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 0, 0, 1, 0};
        vt[18] = '{4'b1001, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 0, 0, 0, 0};
        vt[19] = '{4'b1000, 32'h00000000, 32'h00000000, 32'h00000000, 1, 0, 1, 0};
        vt[20] = '{4'b1010, 32'h00000000, 32'h00000000, 32'h00000000, 1, 0, 1, 0};
        vt[21] = '{4'b1001, 32'h00000000, 32'h00000000, 32'h00000000, 1, 0, 0, 0};
        vt[22] = '{4'b1011, 32'h00000000, 32'h00000000, 32'h00000000, 1, 0, 0, 0};
        vt[23] = '{4'b1001, 32'h00000005, 32'h00000007, 32'h00000005, 0, 0, 1, 0};
        vt[24] = '{4'b1101, 32'h00000005, 32'h00000003, 32'h00000000, 1, 0, 0, 1};
        vt[25] = '{4'b1111, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 0, 0, 1};
        vt[26] = '{4'b0101, 32'hF0F0F0F0, 32'h0F0F0000, 32'h00000F0F, 0, 0, 0, 0};
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.gout      = '0;
        bus.a         = '0;
        bus.b         = '0;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_occupancy", 32'(bus.occupancy), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_result", bus.result, 0);
        do_reset();
        bus.out_ready = 1'b1;
        foreach (vt[i]) begin
            drive(vt[i].g, vt[i].a, vt[i].b);
            tick();
            bus.in_valid = 1'b0;
            chk($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 1);
            chk($sformatf("v%0d_result", i), bus.result, vt[i].r);
            chk($sformatf("v%0d_zero", i), 32'(bus.zero), 32'(vt[i].z));
            chk($sformatf("v%0d_overflow", i), 32'(bus.overflow), 32'(vt[i].o));
            chk($sformatf("v%0d_taken", i), 32'(bus.branch_taken), 32'(vt[i].t));
            chk($sformatf("v%0d_illegal", i), 32'(bus.illegal), 32'(vt[i].il));
        end
        tick();
        chk("drain_out_valid", 32'(bus.out_valid), 0);
        chk("drain_result", bus.result, 0);
        // backpressure: third op must wait until the first pop frees a slot
        bus.out_ready = 1'b0;
        drive(4'b0011, 32'hF0, 32'h0F);
        tick();
        chk("bp_occ1", 32'(bus.occupancy), 1);
        drive(4'b0100, 32'hF0, 32'h3C);
        tick();
        chk("bp_occ2", 32'(bus.occupancy), 2);
        chk("bp_in_ready_full", 32'(bus.in_ready), 0);
        drive(4'b0000, 32'h1, 32'h2);
        tick();
        chk("bp_occ_held", 32'(bus.occupancy), 2);
        chk("bp_in_ready_held", 32'(bus.in_ready), 0);
        bus.out_ready = 1'b1;
        chk("bp_in_ready_full_pop", 32'(bus.in_ready), 0);
        chk("bp_head0", bus.result, 32'hFF);
        tick();
        chk("bp_occ_after_pop", 32'(bus.occupancy), 1);
        chk("bp_head1", bus.result, 32'h30);
        chk("bp_in_ready_free", 32'(bus.in_ready), 1);
        tick();
        bus.in_valid = 1'b0;
        chk("bp_occ_swap", 32'(bus.occupancy), 1);
        chk("bp_head2", bus.result, 32'h03);
        tick();
        chk("bp_empty", 32'(bus.out_valid), 0);
        chk("bp_occ0", 32'(bus.occupancy), 0);
        // streaming: one result per cycle with constant occupancy 1
        for (int i = 0; i < 10; i++) begin
            drive(4'b0000, 32'(i), 32'h1);
            tick();
            chk($sformatf("st%0d_result", i), bus.result, 32'(i + 1));
            chk($sformatf("st%0d_occ", i), 32'(bus.occupancy), 1);
            chk($sformatf("st%0d_out_valid", i), 32'(bus.out_valid), 1);
        end
        bus.in_valid = 1'b0;
        tick();
        chk("st_drain", 32'(bus.out_valid), 0);
        // async reset with two queued entries
        bus.out_ready = 1'b0;
        drive(4'b0011, 32'h1, 32'h2);
        tick();
        tick();
        bus.in_valid = 1'b0;
        chk("ar_occ_before", 32'(bus.occupancy), 2);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_out_valid", 32'(bus.out_valid), 0);
        chk("ar_occ", 32'(bus.occupancy), 0);
        chk("ar_in_ready", 32'(bus.in_ready), 1);
        chk("ar_result", bus.result, 0);
        tick();
        chk("ar_in_ready_held", 32'(bus.in_ready), 1);
        chk("ar_occ_held", 32'(bus.occupancy), 0);
        @(negedge clk);
        reset = 1'b0;
        drive(4'b0001, 32'h5, 32'h5);
        tick();
        bus.in_valid = 1'b0;
        chk("ar_first_accept", 32'(bus.out_valid), 1);
        chk("ar_first_zero", 32'(bus.zero), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
